// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDrain
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry {pc, inst} buffer that parks a fetched instruction while decode stalls.
module if_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_inst;

  // Clear wins so a flush can never leave a stale wrong-path entry behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch_redirect.sv
// Fetch front end: owns the PC, runs the req/ack imem protocol, fills the IF/ID slot
// and redirects/flushes on a taken branch from EX.
module if_fetch_redirect
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = if_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst
);

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic        r_req, w_req_d;
  logic [31:0] r_addr, w_addr_d;
  logic        r_valid, w_valid_d;
  logic [31:0] r_if_pc, w_if_pc_d;
  logic [31:0] r_if_pc4, w_if_pc4_d;
  logic [31:0] r_inst, w_inst_d;

  logic        w_accept;
  logic        w_skid_load, w_skid_clear, w_skid_valid;
  logic [31:0] w_skid_pc, w_skid_inst;

  assign w_accept = !r_valid || !id_stall;

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_pc    (r_pc),
    .i_inst  (imem_rdata),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_inst  (w_skid_inst)
  );

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_valid_d    = r_valid;
    w_if_pc_d    = r_if_pc;
    w_if_pc4_d   = r_if_pc4;
    w_inst_d     = r_inst;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;

    // Decode consumed the slot; it empties unless something new lands below.
    if (!id_stall) begin
      w_valid_d = 1'b0;
      w_inst_d  = NOP_INST;
    end

    if (ex_redirect) begin
      w_pc_d       = align_word(ex_target);
      w_valid_d    = 1'b0;
      w_inst_d     = NOP_INST;
      w_skid_clear = 1'b1;
      unique case (r_state)
        StFetch: w_state_d = imem_ack ? StFetch : StDrain;
        StDrain: w_state_d = imem_ack ? StFetch : StDrain;
        default: w_state_d = StFetch;
      endcase
    end else begin
      unique case (r_state)
        StIdle: w_state_d = StFetch;
        StFetch: begin
          if (imem_ack) begin
            w_pc_d = r_pc + PC_STEP;
            if (w_accept) begin
              w_valid_d  = 1'b1;
              w_if_pc_d  = r_pc;
              w_if_pc4_d = r_pc + PC_STEP;
              w_inst_d   = imem_rdata;
            end else begin
              w_skid_load = 1'b1;
              w_state_d   = StHold;
            end
          end
        end
        StHold: begin
          if (!id_stall && w_skid_valid) begin
            w_valid_d    = 1'b1;
            w_if_pc_d    = w_skid_pc;
            w_if_pc4_d   = w_skid_pc + PC_STEP;
            w_inst_d     = w_skid_inst;
            w_skid_clear = 1'b1;
            w_state_d    = StFetch;
          end
        end
        StDrain: if (imem_ack) w_state_d = StFetch;
        default: w_state_d = StIdle;
      endcase
    end

    // Request/address are registered; DRAIN keeps the in-flight address stable.
    w_req_d  = (w_state_d == StFetch) || (w_state_d == StDrain);
    w_addr_d = (w_state_d == StDrain) ? r_addr : w_pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_pc     <= RESET_PC;
      r_req    <= 1'b0;
      r_addr   <= RESET_PC;
      r_valid  <= 1'b0;
      r_if_pc  <= '0;
      r_if_pc4 <= '0;
      r_inst   <= NOP_INST;
    end else begin
      r_state  <= w_state_d;
      r_pc     <= w_pc_d;
      r_req    <= w_req_d;
      r_addr   <= w_addr_d;
      r_valid  <= w_valid_d;
      r_if_pc  <= w_if_pc_d;
      r_if_pc4 <= w_if_pc4_d;
      r_inst   <= w_inst_d;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign if_valid  = r_valid;
  assign if_pc     = r_if_pc;
  assign if_pc4    = r_if_pc4;
  assign if_inst   = r_inst;

endmodule

// File: tb/tb_if_fetch_redirect.sv
// Directed bench for if_fetch_redirect; imem returns addr + 0x1000_0000 as the instruction.
module tb_if_fetch_redirect;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam logic [31:0] Tag = 32'h1000_0000;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + Tag;

  if_fetch_redirect dut (
    .clk         (clk),
    .rst         (rst),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .id_stall    (id_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4),
    .if_inst     (if_inst)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ex_redirect = 1'b0; ex_target = '0; id_stall = 1'b0; imem_ack = 1'b1;
    step(); step();
    check_eq("rst_req",   {31'b0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst_pc",    if_pc,   32'd0);
    check_eq("rst_pc4",   if_pc4,  32'd0);
    check_eq("rst_inst",  if_inst, Nop);

    // zero-wait streaming
    rst = 1'b0;
    step();
    check_eq("t1_req",    {31'b0, imem_req}, 32'd1);
    check_eq("t1_addr0",  imem_addr, 32'h0);
    check_eq("t1_bubble", {31'b0, if_valid}, 32'd0);
    step();
    check_eq("t1_valid",  {31'b0, if_valid}, 32'd1);
    check_eq("t1_pc0",    if_pc,   32'h0);
    check_eq("t1_pc4_0",  if_pc4,  32'h4);
    check_eq("t1_inst0",  if_inst, 32'h1000_0000);
    check_eq("t1_addr4",  imem_addr, 32'h4);
    step();
    check_eq("t1_pc1",    if_pc,   32'h4);
    check_eq("t1_inst1",  if_inst, 32'h1000_0004);
    check_eq("t1_addr8",  imem_addr, 32'h8);

    // stall with ack: inst at 8 goes to skid
    id_stall = 1'b1;
    step();
    check_eq("t2_req0",   {31'b0, imem_req}, 32'd0);
    check_eq("t2_hold_pc", if_pc, 32'h4);
    step();  // ack without req must be ignored
    check_eq("t2_still",  {31'b0, imem_req}, 32'd0);
    check_eq("t2_still_pc", if_pc, 32'h4);
    id_stall = 1'b0;
    step();
    check_eq("t2_skid_pc",   if_pc,   32'h8);
    check_eq("t2_skid_inst", if_inst, 32'h1000_0008);
    check_eq("t2_resume",    imem_addr, 32'hC);
    check_eq("t2_req1",      {31'b0, imem_req}, 32'd1);
    step();
    check_eq("t2_next_pc",   if_pc, 32'hC);
    check_eq("t2_next_addr", imem_addr, 32'h10);

    // redirect, fetch completes same cycle; low target bits dropped
    ex_redirect = 1'b1; ex_target = 32'h0000_0103;
    step();
    ex_redirect = 1'b0;
    check_eq("t3_flush",  {31'b0, if_valid}, 32'd0);
    check_eq("t3_nop",    if_inst, Nop);
    check_eq("t3_addr",   imem_addr, 32'h100);
    step();
    check_eq("t3_pc",     if_pc, 32'h100);
    check_eq("t3_inst",   if_inst, 32'h1000_0100);

    // redirect with outstanding request
    imem_ack = 1'b0;
    step();
    check_eq("t4_wait_addr", imem_addr, 32'h104);
    ex_redirect = 1'b1; ex_target = 32'h0000_0400;
    step();
    ex_redirect = 1'b0;
    check_eq("t4_held0", imem_addr, 32'h104);
    check_eq("t4_req",   {31'b0, imem_req}, 32'd1);
    step();
    check_eq("t4_held1", imem_addr, 32'h104);
    imem_ack = 1'b1;
    step();
    check_eq("t4_target", imem_addr, 32'h400);
    check_eq("t4_discard", {31'b0, if_valid}, 32'd0);
    step();
    check_eq("t4_pc",   if_pc,   32'h400);
    check_eq("t4_inst", if_inst, 32'h1000_0400);

    // redirect under stall, re-redirect during drain
    imem_ack = 1'b0; id_stall = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_0200;
    step();
    check_eq("t5_flush_stall", {31'b0, if_valid}, 32'd0);
    check_eq("t5_nop",   if_inst, Nop);
    check_eq("t5_held",  imem_addr, 32'h404);
    ex_target = 32'h0000_0300; id_stall = 1'b0;
    step();
    ex_redirect = 1'b0;
    check_eq("t5_held2", imem_addr, 32'h404);
    imem_ack = 1'b1;
    step();
    check_eq("t5_newest", imem_addr, 32'h300);
    step();
    check_eq("t5_pc", if_pc, 32'h300);

    // wrap at top of address space
    ex_redirect = 1'b1; ex_target = 32'hFFFF_FFFC;
    step();
    ex_redirect = 1'b0;
    check_eq("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    check_eq("t6_pc_top", if_pc,  32'hFFFF_FFFC);
    check_eq("t6_pc4",    if_pc4, 32'h0000_0000);
    check_eq("t6_inst",   if_inst, 32'h0FFF_FFFC);
    check_eq("t6_wrap",   imem_addr, 32'h0);

    // reset during an outstanding request
    imem_ack = 1'b0;
    step();
    rst = 1'b1;
    step();
    check_eq("t6_rst_req",   {31'b0, imem_req}, 32'd0);
    check_eq("t6_rst_valid", {31'b0, if_valid}, 32'd0);
    rst = 1'b0; imem_ack = 1'b1;
    step();
    check_eq("t6_restart_req",  {31'b0, imem_req}, 32'd1);
    check_eq("t6_restart_addr", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
